load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
Read-side companion to the byte-lane data memory. It accepts load requests (LB/LH/LW/LBU/LHU) with a byte address and drives the word address to the memory's asynchronous read port. It extracts and aligns the addressed byte, halfword or word, then sign- or zero-extends it. Loads that cross a word boundary are split into two sequential word reads. The result is returned through a valid/ready response handshake to the pipeline writeback stage.

Parameters:
ADDR_W, 6, word-address width of data memory; byte address is ADDR_W+2 bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  load request valid
req_ready  output  1  unit can accept request (high only in IDLE)
req_addr  input  ADDR_W+2  byte address; [1:0] = byte offset, [ADDR_W+1:2] = word address
req_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
mem_adr  output  ADDR_W  word address to data memory read port
mem_rd  input  32  asynchronous read data; byte 0 = bits [7:0] (little-endian)
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_data  output  32  extended load result
rsp_err  output  1  illegal funct3 (or trapped misalignment, see Optional Feature)

Behaviour:
- Reset (async, rst=1): state IDLE; rsp_valid=0, rsp_data=0, rsp_err=0, mem_adr=0; internal buffers = 0. req_ready=1 once rst is released.
- FSM states: IDLE, RD0, RD1, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch word address, offset and funct3.
  - Size: byte=1, half=2, word=4.
  - Illegal funct3 -> RESP with rsp_err=1, rsp_data=0, no memory read.
  - Otherwise -> RD0.
- RD0: mem_adr = latched word. Capture mem_rd into buf0 at clock edge.
  - offset+size <= 4 -> RESP.
  - offset+size > 4 -> RD1.
- RD1: mem_adr = latched word + 1, modulo 2^ADDR_W (word 63 wraps to word 0). Capture mem_rd into buf1 -> RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err registered and held stable until rsp_ready.
  - On rsp_valid && rsp_ready -> IDLE, and rsp_valid drops next cycle.
  - No new request is accepted in the same cycle.
- Assembly: raw = ({buf1,buf0} >> (offset*8))[31:0].
  - LB: sign-extend raw[7:0]. LBU: zero-extend raw[7:0].
  - LH: sign-extend raw[15:0]. LHU: zero-extend raw[15:0].
  - LW: raw.
  - For non-split loads, buf1 is don't-care (masked).
- Latency, measured from the accept edge to rsp_valid high:
  - 2 cycles for an in-word load.
  - 3 cycles for a split load.
  - 1 cycle for an illegal funct3.
- mem_adr holds its last value in IDLE and RESP. The unit never writes memory.
- Inputs are sampled only on accept; req_addr and req_funct3 may change afterwards.
- Reset mid-operation (any state): immediate abort to IDLE, with outputs at their reset values; no response is produced.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: any load that is not naturally aligned (LH/LHU with odd offset, LW with offset != 0) is not executed. The unit goes IDLE -> RESP with rsp_err=1 and rsp_data=0. RD1 is unreachable.
- Undefined: unaligned loads complete normally. In-word unaligned loads take a single read; word-crossing loads take a split read. rsp_err is raised only for illegal funct3.

Test Plan:
1. word0=0x9F5D4A6E -> the following responses, each with rsp_err=0:
   - LB @0x00 -> 0x0000006E.
   - LB @0x03 -> 0xFFFFFF9F.
   - LBU @0x03 -> 0x0000009F.
2. word0=0x9F5D4A6E, rsp_ready=1:
   - LH @0x02 -> 0xFFFF9F5D.
   - LHU @0x02 -> 0x00009F5D.
   - LW @0x00 -> 0x9F5D4A6E, with rsp_valid exactly 2 cycles after accept.
3. word0=0x9F5D4A6E, word1=0x0000000E, LW @0x01 (macro undefined):
   - mem_adr goes 0 then 1.
   - rsp_data=0x0E9F5D4A at accept+3.
   - With MISALIGN_TRAP_EN: rsp_err=1, rsp_data=0 at accept+1.
4. Wrap: word63=0xAB000000, word0=0x000000CD, LH @0xFF:
   - mem_adr goes 63 then 0.
   - rsp_data=0xFFFFCDAB.
5. Back-pressure and illegal funct3:
   - Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_err stay constant and req_ready=0. Release -> IDLE next cycle.
   - funct3=011 -> rsp_err=1, rsp_data=0 at accept+1, with no change on mem_adr.
6. Assert rst while in RD1 -> rsp_valid=0, rsp_data=0, rsp_err=0 immediately. After release, req_ready=1 and no stale response ever appears.

Source files
------------

// File: rtl/load_align_unit.sv
// Load align unit: word reads, byte/half/word extraction, split reads across words.
// Optional MISALIGN_TRAP_EN: reject non-naturally-aligned loads with rsp_err.
module load_align_unit #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic [31:0]       mem_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    RD0,
    RD1,
    RESP
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] word_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [31:0]       buf0_q;
  logic [ADDR_W-1:0] mem_adr_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;
  logic              rsp_valid_q;

  logic [2:0]        size_c;
  logic              split_c;
  logic              req_bad_c;
  logic [31:0]       data0_d;
  logic [31:0]       data1_d;

  function automatic logic [31:0] align(
    input logic [31:0] hi,
    input logic [31:0] lo,
    input logic [1:0]  off,
    input logic [2:0]  f3
  );
    logic [63:0] cat;
    logic [31:0] raw;
    logic [31:0] res;
    cat = {hi, lo};
    raw = cat[{off, 3'b000} +: 32];
    res = raw;
    unique case (1'b1)
      f3[1:0] == 2'b00: res = {{24{raw[7] & ~f3[2]}}, raw[7:0]};
      f3[1:0] == 2'b01: res = {{16{raw[15] & ~f3[2]}}, raw[15:0]};
      default:          res = raw;
    endcase
    return res;
  endfunction

  always_comb begin
    size_c    = f3_q[1] ? 3'd4 : (f3_q[0] ? 3'd2 : 3'd1);
    split_c   = ({1'b0, off_q} + size_c) > 3'd4;
    req_bad_c = (req_funct3[1:0] == 2'b11)
              | (req_funct3[2] & req_funct3[1]);
`ifdef MISALIGN_TRAP_EN
    // Natural alignment: halfwords need even offset, words need offset 0.
    req_bad_c = req_bad_c
              | (req_funct3[0] & req_addr[0])
              | (req_funct3[1] & (req_addr[1:0] != 2'b00));
`endif
    data0_d   = align(32'h0, mem_rd, off_q, f3_q);
    data1_d   = align(mem_rd, buf0_q, off_q, f3_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      buf0_q      <= '0;
      mem_adr_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            word_q <= req_addr[ADDR_W+1:2];
            off_q  <= req_addr[1:0];
            f3_q   <= req_funct3;
            if (req_bad_c) begin
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              mem_adr_q <= req_addr[ADDR_W+1:2];
              state_q   <= RD0;
            end
          end
        end
        RD0: begin
          buf0_q <= mem_rd;
          if (split_c) begin
            mem_adr_q <= word_q + ADDR_W'(1);
            state_q   <= RD1;
          end else begin
            rsp_data_q  <= data0_d;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RD1: begin
          rsp_data_q  <= data1_d;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE) & ~rst;
  assign mem_adr   = mem_adr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: byte-level memory model, random loads.
module tb_load_align_unit;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW+1:0] req_addr;
  logic [2:0]    req_funct3;
  logic [AW-1:0] mem_adr;
  logic [31:0]   mem_rd;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_err;

  logic [31:0] mem [64];

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_adr];

  load_align_unit #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .mem_adr    (mem_adr),
    .mem_rd     (mem_rd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: gather bytes from a flat little-endian byte space.
  function automatic void model(input logic [7:0] a, input logic [2:0] f3,
                                output logic err, output logic [31:0] d,
                                output int lat);
    int sz;
    logic [7:0] ba;
    logic [31:0] v;
    logic [31:0] w;
    err = 1'b0;
    d = 32'h0;
    lat = 1;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
      err = 1'b1;
      return;
    end
    sz = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
`ifdef MISALIGN_TRAP_EN
    if ((int'(a[1:0]) % sz) != 0) begin
      err = 1'b1;
      return;
    end
`endif
    v = 32'h0;
    for (int i = 0; i < sz; i++) begin
      ba = 8'(int'(a) + i);
      w = mem[ba[7:2]];
      v = v | (((w >> (8 * int'(ba[1:0]))) & 32'hFF) << (8 * i));
    end
    if (!f3[2] && sz < 4 && v[8*sz-1])
      v = v | ~((32'h1 << (8 * sz)) - 32'h1);
    d = v;
    lat = ((int'(a[1:0]) + sz) > 4) ? 3 : 2;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_rsp: got data %h with empty scoreboard", rsp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
      end
    end
  end

  task automatic do_load(input logic [7:0] a, input logic [2:0] f3,
                         input int bp);
    logic e;
    logic [31:0] d;
    int lat;
    int cyc;
    logic [AW-1:0] prev;
    logic [AW-1:0] w;
    logic [AW-1:0] w1;
    logic [31:0] hd;
    logic he;
    model(a, f3, e, d, lat);
    sb.push_back('{err: e, data: d});
    w = a[7:2];
    w1 = w + 6'd1;
    @(negedge clk);
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    prev = mem_adr;
    req_addr = a;
    req_funct3 = f3;
    req_valid = 1'b1;
    rsp_ready = (bp == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = 8'($urandom);
    req_funct3 = 3'($urandom);
    if (lat == 1) chk("mem_adr_hold", {26'h0, mem_adr}, {26'h0, prev});
    else chk("mem_adr_rd0", {26'h0, mem_adr}, {26'h0, w});
    cyc = 1;
    while (!rsp_valid && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 2 && lat == 3)
        chk("mem_adr_rd1", {26'h0, mem_adr}, {26'h0, w1});
    end
    chk("latency", cyc, lat);
    if (!rsp_valid) begin
      void'(sb.pop_back());
      rsp_ready = 1'b1;
      return;
    end
    if (bp > 0) begin
      hd = rsp_data;
      he = rsp_err;
      repeat (bp) begin
        @(posedge clk);
        #1;
        chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("bp_data", rsp_data, hd);
        chk("bp_err", {31'h0, rsp_err}, {31'h0, he});
        chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
    chk("req_ready_back", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_funct3 = '0;
    rsp_ready = 1'b1;
    #12;
    chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_adr", {26'h0, mem_adr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("req_ready_after_rst", {31'h0, req_ready}, 32'h1);

    mem[0] = 32'h9F5D4A6E;
    do_load(8'h00, 3'b000, 0);
    do_load(8'h03, 3'b000, 0);
    do_load(8'h03, 3'b100, 0);
    do_load(8'h02, 3'b001, 0);
    do_load(8'h02, 3'b101, 0);
    do_load(8'h00, 3'b010, 0);
    mem[1] = 32'h0000000E;
    do_load(8'h01, 3'b010, 0);
    mem[63] = 32'hAB000000;
    mem[0] = 32'h000000CD;
    do_load(8'hFF, 3'b001, 0);
    mem[0] = 32'h9F5D4A6E;
    do_load(8'h00, 3'b010, 5);
    do_load(8'h05, 3'b011, 0);
    do_load(8'h06, 3'b111, 2);

    // Abort during the second read of a word-crossing load.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_addr = 8'h03;
    req_funct3 = 3'b001;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_data", rsp_data, 32'h0);
    chk("mid_rst_err", {31'h0, rsp_err}, 32'h0);
    chk("mid_rst_adr", {26'h0, mem_adr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("post_rst_valid", {31'h0, rsp_valid}, 32'h0);
      chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
    end

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 63)] = $urandom;
      do_load(8'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
